// File: rtl/llc_repl_ctrl.sv
// rtl/llc_repl_ctrl.sv - per-set tree-PLRU state owner and request sequencer for the LLC
//
// Holds N_WAY-1 PLRU bits per set and serialises TOUCH / VICTIM / CLEAR requests,
// one outstanding request at a time. The tree is walked one level per cycle and the
// updated bits are written back before the next request is accepted.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   req_valid/ready  request handshake; ready only while idle
//   req_op           00 TOUCH, 01 VICTIM, 10 CLEAR, 11 reserved
//   req_set          target set
//   req_way          accessed way (TOUCH)
//   req_inv          per-way invalid mask (VICTIM)
//   rsp_valid        one-cycle response pulse
//   rsp_way          TOUCH echo / VICTIM choice / CLEAR zero
//   rsp_err          reserved op flag, qualified by rsp_valid
//   init_done        post-reset storage sweep finished
module llc_repl_ctrl #(
    parameter int N_WAY = 16,
    parameter int N_SET = 1024,
    localparam int L     = $clog2(N_WAY),
    localparam int SET_W = $clog2(N_SET),
    localparam int BITS  = N_WAY - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [SET_W-1:0] req_set,
    input  logic [L-1:0]     req_way,
    input  logic [N_WAY-1:0] req_inv,
    output logic             rsp_valid,
    output logic [L-1:0]     rsp_way,
    output logic             rsp_err,
    output logic             init_done
);

    localparam logic [1:0] OP_TOUCH  = 2'b00;
    localparam logic [1:0] OP_VICTIM = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_READ,
        S_WALK,
        S_WRITE,
        S_ERR
    } state_t;

    state_t state, state_nx;

    logic [BITS-1:0]  mem [N_SET];

    logic [SET_W-1:0] init_cnt;
    logic [SET_W-1:0] set_q;
    logic [BITS-1:0]  bits_q;
    logic [L-1:0]     node_q;
    logic [L-1:0]     lvl_q;     // levels remaining minus one
    logic [L-1:0]     tgt_q;     // forced path, consumed MSB first
    logic             use_tgt_q; // follow tgt_q instead of the PLRU bits
    logic [L-1:0]     way_q;

    logic             dir;
    logic [BITS-1:0]  bits_nx;
    logic [L-1:0]     way_nx;
    logic [L:0]       node_w;
    logic [L-1:0]     inv_idx;

    // Lowest-numbered invalid way: scan from the top so the lowest hit wins.
    always_comb begin
        inv_idx = '0;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (req_inv[i]) inv_idx = L'(i);
        end
    end

    // One tree level: pick a side, record it in the node bit and the way being built.
    always_comb begin
        dir     = use_tgt_q ? tgt_q[L-1] : ~bits_q[node_q];
        bits_nx = bits_q;
        bits_nx[node_q] = dir;
        way_nx  = (way_q << 1) | L'(dir);
        node_w  = {node_q, 1'b0} + (L+1)'(1) + (L+1)'(dir);
    end

    always_comb begin
        state_nx  = state;
        req_ready = (state == S_IDLE);
        case (state)
            S_INIT:  if (init_cnt == SET_W'(N_SET - 1)) state_nx = S_IDLE;
            S_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_RSVD:  state_nx = S_ERR;
                        OP_CLEAR: state_nx = S_WRITE;
                        default:  state_nx = S_READ;
                    endcase
                end
            end
            S_READ:  state_nx = S_WALK;
            S_WALK:  if (lvl_q == '0) state_nx = S_WRITE;
            S_WRITE: state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
            set_q     <= '0;
            bits_q    <= '0;
            node_q    <= '0;
            lvl_q     <= '0;
            tgt_q     <= '0;
            use_tgt_q <= 1'b0;
            way_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_way   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            rsp_valid <= 1'b0;
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == SET_W'(N_SET - 1)) init_done <= 1'b1;
                end
                S_IDLE: begin
                    if (req_valid) begin
                        set_q  <= req_set;
                        node_q <= '0;
                        way_q  <= '0;
                        lvl_q  <= L'(L - 1);
                        case (req_op)
                            OP_TOUCH: begin
                                tgt_q     <= req_way;
                                use_tgt_q <= 1'b1;
                            end
                            OP_VICTIM: begin
                                tgt_q     <= inv_idx;
                                use_tgt_q <= |req_inv;
                            end
                            OP_CLEAR: begin
                                bits_q    <= '0;
                                rsp_valid <= 1'b1;
                                rsp_way   <= '0;
                                rsp_err   <= 1'b0;
                            end
                            default: begin
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                S_READ: bits_q <= mem[set_q];
                S_WALK: begin
                    bits_q <= bits_nx;
                    way_q  <= way_nx;
                    node_q <= node_w[L-1:0];
                    tgt_q  <= tgt_q << 1;
                    lvl_q  <= lvl_q - 1'b1;
                    // Response registers load on the last level so they line up with WRITE.
                    if (lvl_q == '0) begin
                        rsp_valid <= 1'b1;
                        rsp_way   <= way_nx;
                        rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage has no reset; the INIT sweep is its only initialisation.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[init_cnt] <= '0;
        end else if (state == S_WRITE) begin
            mem[set_q] <= bits_q;
        end
    end

endmodule

// File: tb/tb_llc_repl_ctrl.sv
// tb/tb_llc_repl_ctrl.sv - scoreboard bench for llc_repl_ctrl (N_WAY=8, N_SET=4)
module tb_llc_repl_ctrl;

    localparam int N_WAY = 8;
    localparam int N_SET = 4;
    localparam int L     = 3;
    localparam int SET_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = '0;
    logic [SET_W-1:0] req_set = '0;
    logic [L-1:0]     req_way = '0;
    logic [N_WAY-1:0] req_inv = '0;
    logic             rsp_valid;
    logic [L-1:0]     rsp_way;
    logic             rsp_err;
    logic             init_done;

    llc_repl_ctrl #(.N_WAY(N_WAY), .N_SET(N_SET)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_set   (req_set),
        .req_way   (req_way),
        .req_inv   (req_inv),
        .rsp_valid (rsp_valid),
        .rsp_way   (rsp_way),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int way;
        int err;
        int due;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_way = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("rsp_way", int'(rsp_way), e.way);
                    check("rsp_err", int'(rsp_err), e.err);
                    check("rsp_cycle", cyc, e.due);
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [1:0] set, input logic [2:0] way,
                        input logic [7:0] inv, input int exp_way, input string tag);
        int   n;
        int   t;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_set   = set;
        req_way   = way;
        req_inv   = inv;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({tag, "_accept_timeout"}, 0, 1);
            req_valid = 1'b0;
            return;
        end
        t = cyc;
        e.err = (op == 2'b11) ? 1 : 0;
        e.due = op[1] ? t + 1 : t + 2 + L;
        if (op == 2'b11) begin
            e.way = last_way;
        end else begin
            e.way    = exp_way;
            last_way = exp_way;
        end
        sbq.push_back(e);
        @(negedge clk);
        // Junk on the request bus outside the handshake must be ignored.
        req_valid = 1'b0;
        req_op    = ~op;
        req_set   = ~set;
        req_way   = ~way;
        req_inv   = ~inv;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_gap"}, cyc - t, op[1] ? 2 : 3 + L);
    endtask

    task automatic release_and_sweep(input string tag);
        int n;
        rst_n = 1'b1;
        #1;
        n = 0;
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, "_init_cycles"}, n, N_SET);
        check({tag, "_init_done"}, int'(init_done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_way", int'(rsp_way), 0);
        check("rst_rsp_err", int'(rsp_err), 0);
        check("rst_init_done", int'(init_done), 0);

        release_and_sweep("boot");

        // TOUCH set2 way5 leaves nodes 0,5 = 1 and node 2 = 0, so next victim is way 3.
        send(2'b00, 2'd2, 3'd5, 8'h00, 5, "touch_s2");
        send(2'b01, 2'd2, 3'd0, 8'h00, 3, "victim_s2_after_touch");

        send(2'b01, 2'd1, 3'd0, 8'h00, 7, "victim_s1_fresh");
        send(2'b01, 2'd1, 3'd0, 8'h00, 3, "victim_s1_repeat");

        // Invalid way forces the path; afterwards root points lower, so PLRU goes upper.
        send(2'b01, 2'd0, 3'd0, 8'b0010_0100, 2, "victim_s0_inv");
        send(2'b01, 2'd0, 3'd0, 8'h00, 7, "victim_s0_plru");
        send(2'b01, 2'd0, 3'd0, 8'b1000_0000, 7, "victim_s0_inv_top");

        send(2'b00, 2'd3, 3'd5, 8'h00, 5, "touch_s3");
        send(2'b11, 2'd3, 3'd0, 8'hff, 0, "reserved_s3");
        send(2'b01, 2'd3, 3'd0, 8'h00, 3, "victim_s3_unchanged");

        send(2'b10, 2'd2, 3'd6, 8'h00, 0, "clear_s2");
        send(2'b01, 2'd2, 3'd0, 8'h00, 7, "victim_s2_cleared");

        // Reset asserted while the tree walk is in progress.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_set   = 2'd1;
        req_inv   = '0;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", int'(req_ready), 0);
        check("abort_rsp_valid", int'(rsp_valid), 0);
        check("abort_init_done", int'(init_done), 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_rsp", int'(rsp_valid), 0);
        end
        release_and_sweep("reinit");

        for (int s = 0; s < N_SET; s++) begin
            send(2'b01, 2'(s), 3'd0, 8'h00, 7, "victim_after_reinit");
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
